// File: rtl/hazard_stall_ctrl_if.sv
// Stage-control bundle between the hazard controller and the pipeline:
// hazard sources in, per-stage enables and flush/bubble controls out.
interface hazard_stall_ctrl_if;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] ex_rd;
  logic       ex_is_load;
  logic       ex_reg_write;
  logic       ex_redirect;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_en;
  logic       idex_bubble;
  logic       exmem_en;
  logic       memwb_en;

  modport master (
    output id_opcode, id_rs1, id_rs2,
    output ex_rd, ex_is_load, ex_reg_write, ex_redirect,
    output mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush,
    input  idex_en, idex_bubble, exmem_en, memwb_en
  );

  modport slave (
    input  id_opcode, id_rs1, id_rs2,
    input  ex_rd, ex_is_load, ex_reg_write, ex_redirect,
    input  mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush,
    output idex_en, idex_bubble, exmem_en, memwb_en
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing: load-use stalls, redirect flushes, memory waits,
// plus a saturating stall counter and a sticky memory-timeout flag.
module hazard_stall_ctrl #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  hazard_stall_ctrl_if.slave hif,
  output logic [CNT_W-1:0]   stall_count,
  output logic               mem_timeout,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic rs1_used, rs2_used;
  logic load_use, mem_stall;

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (hif.id_opcode)
      7'b1100111: rs1_used = 1'b1;
      7'b0000011: rs1_used = 1'b1;
      7'b0100011: rs1_used = 1'b1;
      7'b0010011: rs1_used = 1'b1;
      7'b0110011: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      7'b1100011: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      default: ;
    endcase
  end

  assign load_use = hif.ex_is_load & hif.ex_reg_write
                  & (hif.ex_rd != 5'd0)
                  & ((rs1_used & (hif.id_rs1 == hif.ex_rd))
                   | (rs2_used & (hif.id_rs2 == hif.ex_rd)));

  assign mem_stall = hif.mem_req & ~hif.mem_ready;

  always_comb begin
    hif.pc_en       = 1'b1;
    hif.ifid_en     = 1'b1;
    hif.ifid_flush  = 1'b0;
    hif.idex_en     = 1'b1;
    hif.idex_bubble = 1'b0;
    hif.exmem_en    = 1'b1;
    hif.memwb_en    = 1'b1;
    state_d         = RUN;
    if (rst) begin
      hif.pc_en       = 1'b0;
      hif.ifid_flush  = 1'b1;
      hif.idex_bubble = 1'b1;
    end else if (mem_stall) begin
      hif.pc_en    = 1'b0;
      hif.ifid_en  = 1'b0;
      hif.idex_en  = 1'b0;
      hif.exmem_en = 1'b0;
      hif.memwb_en = 1'b0;
      state_d      = MEM_WAIT;
    end else if (hif.ex_redirect) begin
      hif.ifid_flush  = 1'b1;
      hif.idex_bubble = 1'b1;
    end else if (load_use && state_q != LU_STALL) begin
      // MEM_WAIT releasing on mem_ready evaluates like RUN
      hif.pc_en       = 1'b0;
      hif.ifid_en     = 1'b0;
      hif.idex_bubble = 1'b1;
      state_d         = LU_STALL;
    end
  end

  always_comb begin
    wait_d        = 8'd0;
    mem_timeout_d = mem_timeout_q;
    stall_count_d = stall_count_q;
    if (rst) begin
      mem_timeout_d = 1'b0;
      stall_count_d = '0;
    end else begin
      if (state_q == MEM_WAIT && mem_stall) begin
        wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
        if (wait_q == WAIT_LAST)
          mem_timeout_d = 1'b1;
      end
      if (!hif.pc_en && stall_count_q != '1)
        stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    wait_q        <= wait_d;
    mem_timeout_q <= mem_timeout_d;
    stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
  assign mem_timeout = mem_timeout_q;
  assign state_o     = state_q;

endmodule
